// File: rtl/hspi_pkg.sv
// hspi_pkg: shared direction state encoding, turnaround counter width and default sizes for the HSPI pad bridge
package hspi_pkg;
  localparam int CNT_W = 4;
  localparam int DW_DEF = 16;
  localparam int TURN_CYC_DEF = 2;
  typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} dir_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser (clock, reset, d -> q) with synchronous active-high reset
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clock) begin
    if (reset) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/hspi_pad_bridge.sv
// hspi_pad_bridge: HSPI core-to-pad bridge (core tx/rx, pad data/oeb/strobes, async_in->sync_out); HSPI_LOOPBACK_EN adds loopback port
module hspi_pad_bridge
  import hspi_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SYNC_N = 8,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_oen,
  input  logic              core_tx_enable,
  input  logic [DW-1:0]     core_tx_data,
  output logic              core_tx_ready,
  output logic              core_rx_enable,
  output logic [DW-1:0]     core_rx_data,
  output logic              err_drop,
  input  logic [DW-1:0]     pad_in,
  output logic [DW-1:0]     pad_out,
  output logic [DW-1:0]     pad_oeb,
  input  logic              pad_rx_en_in,
  output logic              pad_tx_en_out,
`ifdef HSPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [SYNC_N-1:0] async_in,
  output logic [SYNC_N-1:0] sync_out
);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);
  dir_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic lb, turn_start, tx_go;
`ifdef HSPI_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif
  assign turn_start = (state == RX && !core_oen) || (state == TX && core_oen);
  assign core_tx_ready = lb || state == TX;
  assign tx_go = state == TX && state_n == TX;
  always_comb begin
    state_n = lb ? RX :
              state == RX ? (core_oen ? RX : TURN_TX) :
              state == TX ? (core_oen ? TURN_RX : TX) :
              cnt != '0 ? state :
              state == TURN_TX ? TX : RX;
    cnt_n = turn_start ? TURN_LD : cnt != '0 ? cnt - CNT_W'(1) : cnt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RX;
      cnt <= '0;
      pad_oeb <= '1;
      pad_out <= '0;
      pad_tx_en_out <= 1'b0;
      core_rx_enable <= 1'b0;
      core_rx_data <= '0;
      err_drop <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pad_oeb <= {DW{state_n != TX}};
      pad_tx_en_out <= tx_go && core_tx_enable;
      pad_out <= !tx_go ? '0 : core_tx_enable ? core_tx_data : pad_out;
      core_rx_enable <= lb ? core_tx_enable : state == RX && pad_rx_en_in;
      core_rx_data <= lb ? core_tx_data : state == RX ? pad_in : '0;
      err_drop <= err_drop || (core_tx_enable && !core_tx_ready);
    end
  end
  for (genvar i = 0; i < SYNC_N; i++) begin : g_sync
    sync_2ff u_sync (
      .clock(clock),
      .reset(reset),
      .d(async_in[i]),
      .q(sync_out[i])
    );
  end
endmodule

// File: tb/tb_hspi_pad_bridge.sv
// tb_hspi_pad_bridge: table-driven and sequence checks of hspi_pad_bridge (HSPI_LOOPBACK_EN enables loopback checks)
module tb_hspi_pad_bridge;
  logic clock = 1'b0;
  logic reset, core_oen, core_tx_enable, core_tx_ready, core_rx_enable, err_drop, pad_rx_en_in, pad_tx_en_out;
  logic [15:0] core_tx_data, core_rx_data, pad_in, pad_out, pad_oeb;
  logic [7:0] async_in, sync_out;
`ifdef HSPI_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  hspi_pad_bridge #(.DW(16), .SYNC_N(8), .TURN_CYC(2)) dut (
    .clock(clock),
    .reset(reset),
    .core_oen(core_oen),
    .core_tx_enable(core_tx_enable),
    .core_tx_data(core_tx_data),
    .core_tx_ready(core_tx_ready),
    .core_rx_enable(core_rx_enable),
    .core_rx_data(core_rx_data),
    .err_drop(err_drop),
    .pad_in(pad_in),
    .pad_out(pad_out),
    .pad_oeb(pad_oeb),
    .pad_rx_en_in(pad_rx_en_in),
    .pad_tx_en_out(pad_tx_en_out),
`ifdef HSPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .async_in(async_in),
    .sync_out(sync_out)
  );
  typedef struct {
    logic rst, oen, txe;
    logic [15:0] txd;
    logic rxe;
    logic [15:0] pin;
    logic [7:0] as;
    logic oeb;
    logic [15:0] pout;
    logic ptx, rdy, rxen;
    logic [15:0] rxd;
    logic err;
    logic [7:0] sy;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    logic sq_oen [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic sq_rdy [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic sq_oeb [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic sq_rxen [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[4]  = '{1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b0, 16'h0000, 8'h00, 1'b0, 16'hA5C3, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b0, 16'hA5C3, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h00};
    v[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5555, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 8'h00};
    v[11] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00};
    v[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h08, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00};
    v[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h08, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h08};
    v[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h08, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h08};
    v[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h08, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h08, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00};
    v[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h08, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h08};
    for (int k = 0; k < 18; k++) begin
      reset = v[k].rst;
      core_oen = v[k].oen;
      core_tx_enable = v[k].txe;
      core_tx_data = v[k].txd;
      pad_rx_en_in = v[k].rxe;
      pad_in = v[k].pin;
      async_in = v[k].as;
      step();
      chk("pad_oeb", k, 32'(pad_oeb), 32'({16{v[k].oeb}}));
      chk("pad_out", k, 32'(pad_out), 32'(v[k].pout));
      chk("pad_tx_en_out", k, 32'(pad_tx_en_out), 32'(v[k].ptx));
      chk("core_tx_ready", k, 32'(core_tx_ready), 32'(v[k].rdy));
      chk("core_rx_enable", k, 32'(core_rx_enable), 32'(v[k].rxen));
      chk("core_rx_data", k, 32'(core_rx_data), 32'(v[k].rxd));
      chk("err_drop", k, 32'(err_drop), 32'(v[k].err));
      chk("sync_out", k, 32'(sync_out), 32'(v[k].sy));
    end
    pad_rx_en_in = 1'b1;
    pad_in = 16'hABCD;
    core_tx_enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      core_oen = sq_oen[k];
      step();
      chk("seq_ready", k, 32'(core_tx_ready), 32'(sq_rdy[k]));
      chk("seq_oeb", k, 32'(pad_oeb), 32'({16{sq_oeb[k]}}));
      chk("seq_rxen", k, 32'(core_rx_enable), 32'(sq_rxen[k]));
      chk("seq_rxdata", k, 32'(core_rx_data), sq_rxen[k] ? 32'h0000ABCD : 32'h0);
      chk("seq_err", k, 32'(err_drop), 32'h0);
    end
`ifdef HSPI_LOOPBACK_EN
    pad_rx_en_in = 1'b0;
    loopback = 1'b1;
    core_oen = 1'b0;
    step();
    chk("lb_oeb", 0, 32'(pad_oeb), 32'hFFFF);
    chk("lb_ready", 0, 32'(core_tx_ready), 32'h1);
    chk("lb_rxen_idle", 0, 32'(core_rx_enable), 32'h0);
    core_tx_enable = 1'b1;
    core_tx_data = 16'hBEEF;
    step();
    chk("lb_rxen", 1, 32'(core_rx_enable), 32'h1);
    chk("lb_rxdata", 1, 32'(core_rx_data), 32'h0000BEEF);
    chk("lb_oeb", 1, 32'(pad_oeb), 32'hFFFF);
    chk("lb_pad_out", 1, 32'(pad_out), 32'h0);
    chk("lb_err", 1, 32'(err_drop), 32'h0);
    core_tx_enable = 1'b0;
    step();
    chk("lb_rxen_off", 2, 32'(core_rx_enable), 32'h0);
    chk("lb_err", 2, 32'(err_drop), 32'h0);
    loopback = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
